// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount as 10/5/1 coins over a valid/ack
// handshake, tracking per-denomination inventory and reporting shortfall.
module change_dispenser #(
  parameter int CNT_W  = 4,
  parameter int INIT10 = 4,
  parameter int INIT5  = 4,
  parameter int INIT1  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispense_in,
  input  logic [4:0]       change_in,
  input  logic             eject_ack,
  input  logic             refill,
  input  logic [1:0]       refill_sel,
  output logic             eject_valid,
  output logic [3:0]       eject_coin,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [4:0]       owed,
  output logic             overrun,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_EJECT  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_SHORT  = 3'd5;

  localparam logic [CNT_W-1:0] INIT10_C = CNT_W'(INIT10);
  localparam logic [CNT_W-1:0] INIT5_C  = CNT_W'(INIT5);
  localparam logic [CNT_W-1:0] INIT1_C  = CNT_W'(INIT1);

  logic [2:0]       state_q, state_d;
  logic [4:0]       rem_q, rem_d;
  logic [3:0]       coin_q, coin_d;
  logic [4:0]       owed_q, owed_d;
  logic [CNT_W-1:0] cnt10_q, cnt10_d;
  logic [CNT_W-1:0] cnt5_q, cnt5_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             xfer;

  // Saturating increment on refill; a simultaneous refill and payout cancel.
  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
    if (inc && !dec && c != '1) return c + CNT_W'(1);
    if (dec && !inc)            return c - CNT_W'(1);
    return c;
  endfunction

  assign xfer = (state_q == S_EJECT) && eject_ack;

  // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    owed_d  = owed_q;
    case (state_q)
      S_IDLE: if (dispense_in) state_d = S_LOAD;
      S_LOAD: begin
        rem_d   = change_in;
        owed_d  = '0;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        if (rem_q == 5'd0) begin
          state_d = S_DONE;
        end else if (rem_q >= 5'd10 && cnt10_q != '0) begin
          coin_d  = 4'd10;
          state_d = S_EJECT;
        end else if (rem_q >= 5'd5 && cnt5_q != '0) begin
          coin_d  = 4'd5;
          state_d = S_EJECT;
        end else if (cnt1_q != '0) begin
          coin_d  = 4'd1;
          state_d = S_EJECT;
        end else begin
          owed_d  = rem_q;
          state_d = S_SHORT;
        end
      end
      S_EJECT: if (eject_ack) begin
        // Selection guaranteed coin_q <= rem_q, so this cannot underflow.
        rem_d   = rem_q - {1'b0, coin_q};
        state_d = S_SELECT;
      end
      S_DONE:  state_d = S_IDLE;
      S_SHORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cnt10_d = step_cnt(cnt10_q, refill && refill_sel == 2'd2, xfer && coin_q == 4'd10);
    cnt5_d  = step_cnt(cnt5_q,  refill && refill_sel == 2'd1, xfer && coin_q == 4'd5);
    cnt1_d  = step_cnt(cnt1_q,  refill && refill_sel == 2'd0, xfer && coin_q == 4'd1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      coin_q  <= '0;
      owed_q  <= '0;
      cnt10_q <= INIT10_C;
      cnt5_q  <= INIT5_C;
      cnt1_q  <= INIT1_C;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      owed_q  <= owed_d;
      cnt10_q <= cnt10_d;
      cnt5_q  <= cnt5_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign eject_valid = (state_q == S_EJECT);
  assign eject_coin  = eject_valid ? coin_q : 4'd0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign short       = (state_q == S_SHORT);
  assign overrun     = dispense_in && busy;
  assign owed        = owed_q;
  assign cnt10       = cnt10_q;
  assign cnt5        = cnt5_q;
  assign cnt1        = cnt1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a reference payout model pushes
// expected coins to a queue, popped and compared as the DUT hands coins over.
module tb_change_dispenser;

  localparam int CNT_W = 4;
  localparam int I10 = 4, I5 = 4, I1 = 8;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispense_in;
  logic [4:0]       change_in;
  logic             eject_ack;
  logic             refill;
  logic [1:0]       refill_sel;
  logic             eject_valid;
  logic [3:0]       eject_coin;
  logic             busy, done, short, overrun;
  logic [4:0]       owed;
  logic [CNT_W-1:0] cnt10, cnt5, cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int m10, m5, m1, m_owed;

  always #5 clk = ~clk;

  change_dispenser #(.CNT_W(CNT_W), .INIT10(I10), .INIT5(I5), .INIT1(I1)) dut (
    .clk(clk), .rst(rst), .dispense_in(dispense_in), .change_in(change_in),
    .eject_ack(eject_ack), .refill(refill), .refill_sel(refill_sel),
    .eject_valid(eject_valid), .eject_coin(eject_coin), .busy(busy),
    .done(done), .short(short), .owed(owed), .overrun(overrun),
    .cnt10(cnt10), .cnt5(cnt5), .cnt1(cnt1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt10"}, int'(cnt10), m10);
    check({tag, "_cnt5"},  int'(cnt5),  m5);
    check({tag, "_cnt1"},  int'(cnt1),  m1);
  endtask

  // Reference payout: greedy 10/5/1 over the model inventory.
  task automatic predict(input int chg, output bit exp_done);
    int rem = chg;
    exp_done = 1'b0;
    forever begin
      if (rem == 0) begin exp_done = 1'b1; m_owed = 0; break; end
      if (rem >= 10 && m10 > 0)     begin exp_q.push_back(10); m10--; rem -= 10; end
      else if (rem >= 5 && m5 > 0)  begin exp_q.push_back(5);  m5--;  rem -= 5;  end
      else if (m1 > 0)              begin exp_q.push_back(1);  m1--;  rem -= 1;  end
      else begin m_owed = rem; break; end
    end
  endtask

  task automatic refill_coin(input logic [1:0] sel);
    refill = 1'b1; refill_sel = sel;
    @(posedge clk); #1;
    refill = 1'b0;
    case (sel)
      2'd0: if (m1  < MAXC) m1++;
      2'd1: if (m5  < MAXC) m5++;
      2'd2: if (m10 < MAXC) m10++;
      default: ;
    endcase
  endtask

  // One sale. stall: cycles ack is held low on the first coin; ovr: pulse
  // dispense_in during EJECT; rf10: refill a 10 on the cycle a 10 is acked.
  task automatic sale(input int chg, input int stall, input bit ovr, input bit rf10);
    bit exp_done, fin, has_coins, valid_seen, ovr_done, ovr_clr, rf_done, rf_chk;
    int stall_left, pre10;
    pre10 = m10;
    predict(chg, exp_done);
    has_coins  = (exp_q.size() > 0);
    fin = 0; valid_seen = 0; ovr_done = 0; ovr_clr = 0; rf_done = 0; rf_chk = 0;
    stall_left = stall;
    eject_ack  = 1'b1;
    @(posedge clk); #1 dispense_in = 1'b1;
    @(posedge clk); #1 dispense_in = 1'b0; change_in = 5'(chg);
    for (int n = 1; n <= 300 && !fin; n++) begin
      @(negedge clk);
      if (ovr_clr) begin dispense_in = 1'b0; ovr_clr = 0; end
      if (rf_chk) begin
        refill = 1'b0; rf_chk = 0;
        check("refill_vs_ack_cnt10", int'(cnt10), pre10);
      end
      if (eject_valid) valid_seen = 1;
      if (n == 3) begin
        if (has_coins) check("lat_first_valid", int'(eject_valid), 1);
        if (chg == 0)  check("lat_zero_done", int'(done), 1);
      end
      if (eject_valid && stall_left > 0) begin
        eject_ack = 1'b0;
        stall_left--;
        if (exp_q.size() > 0) check("stall_coin", int'(eject_coin), exp_q[0]);
        check("stall_cnt10", int'(cnt10), pre10);
      end else begin
        eject_ack = 1'b1;
      end
      if (eject_valid && ovr && !ovr_done) begin
        dispense_in = 1'b1; ovr_done = 1; ovr_clr = 1;
        #1 check("overrun_pulse", int'(overrun), 1);
      end
      if (eject_valid && eject_ack) begin
        if (exp_q.size() == 0) check("extra_coin", int'(eject_coin), 0);
        else check("coin", int'(eject_coin), exp_q.pop_front());
        if (rf10 && !rf_done && eject_coin == 4'd10) begin
          refill = 1'b1; refill_sel = 2'd2; rf_done = 1; rf_chk = 1;
          m10++;
        end
      end
      if (done || short) begin
        fin = 1;
        check("done", int'(done), int'(exp_done));
        check("short", int'(short), int'(!exp_done));
        check("owed", int'(owed), m_owed);
        check("overrun_idle", int'(overrun), 0);
        @(negedge clk);
        check("busy_after_end", int'(busy), 0);
      end
    end
    if (!fin) check("timeout", 0, 1);
    if (!has_coins) check("no_valid", int'(valid_seen), 0);
    check("queue_left", exp_q.size(), 0);
    check_counts("sale");
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b1; dispense_in = 1'b0; change_in = '0; eject_ack = 1'b1;
    refill = 1'b0; refill_sel = '0;
    m10 = I10; m5 = I5; m1 = I1; m_owed = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(eject_valid), 0);
    check("rst_coin", int'(eject_coin), 0);
    check("rst_done", int'(done), 0);
    check("rst_short", int'(short), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_owed", int'(owed), 0);
    check_counts("rst");

    // 17 from full inventory: 10,5,1,1
    sale(17, 0, 0, 0);
    check("t1_cnt10", int'(cnt10), 3);
    check("t1_cnt5", int'(cnt5), 3);
    check("t1_cnt1", int'(cnt1), 6);

    sale(0, 0, 0, 0);

    // Drain the 10s, then 10 is paid as 5,5
    repeat (3) sale(10, 0, 0, 0);
    check("drained_cnt10", int'(cnt10), 0);
    sale(10, 0, 0, 0);

    // Leave a single 1, then a 3-unit sale falls short by 2
    sale(5, 0, 0, 0);
    sale(5, 0, 0, 0);
    check("pre_short_cnt1", int'(cnt1), 1);
    sale(3, 0, 0, 0);
    check("short_owed", int'(owed), 2);
    check("short_cnt1", int'(cnt1), 0);
    sale(0, 0, 0, 0);

    // Reset during EJECT aborts the payout and restores inventory
    refill_coin(2'd0);
    eject_ack = 1'b0;
    @(posedge clk); #1 dispense_in = 1'b1;
    @(posedge clk); #1 dispense_in = 1'b0; change_in = 5'd5;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (eject_valid) seen = 1;
    end
    check("abort_reached_eject", int'(seen), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    m10 = I10; m5 = I5; m1 = I1; m_owed = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(eject_valid), 0);
    check("abort_coin", int'(eject_coin), 0);
    check_counts("abort");
    rst = 1'b0;
    eject_ack = 1'b1;

    // Backpressure on the first coin plus an overrun pulse
    sale(17, 3, 1, 0);

    // Refill of 10 on the same edge a 10 is acked
    sale(10, 0, 0, 1);

    // cnt5 saturates; refill_sel=3 is ignored
    repeat (14) refill_coin(2'd1);
    check("sat_cnt5", int'(cnt5), MAXC);
    refill_coin(2'd1);
    check("sat_cnt5_hold", int'(cnt5), MAXC);
    refill_coin(2'd3);
    @(negedge clk);
    check_counts("sel3");

    sale(28, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
